// File: rtl/riscv_soc.sv
// Minimal RV32I SoC: single-cycle core (riscv_inst) fetching from an instruction ROM (rom_inst).
// Optional data RAM for loads/stores is enabled by defining RISCV_SOC_DATA_RAM_EN.

module riscv_rom #(
    parameter int ROM_DEPTH = 4096,
    parameter int ROM_AW    = $clog2(ROM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ROM_AW-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [31:0]       o_data
);
    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    // Loader port; contents are otherwise preloaded by the simulation environment.
    always_ff @(posedge i_clk) begin
        if (i_we) rom_mem[i_waddr] <= i_wdata;
    end

    assign o_data = rom_mem[i_addr];
endmodule

module riscv_regs (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);
    logic [31:0] regs [0:31];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : regs[i_raddr2];
endmodule

module riscv_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic [31:0] i_dmem_rdata
);
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_ST    = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;

    logic [31:0] r_pc;
    logic [31:0] w_next_pc, w_pc4, w_rs1, w_rs2, w_wd, w_ld_shift, w_ld_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [3:0]  w_be_raw;
    logic        w_we, w_taken, w_is_store;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
        logic [31:0] res;
        case (f3)
            3'b000:  res = alt ? (a - b) : (a + b);
            3'b001:  res = a << b[4:0];
            3'b010:  res = {31'd0, $signed(a) < $signed(b)};
            3'b011:  res = {31'd0, a < b};
            3'b100:  res = a ^ b;
            3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    assign w_op    = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'd0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_pc4   = r_pc + 32'd4;

    riscv_regs regs_inst (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_raddr1 (i_instr[19:15]),
        .i_raddr2 (i_instr[24:20]),
        .o_rdata1 (w_rs1),
        .o_rdata2 (w_rs2),
        .i_we     (w_we),
        .i_waddr  (i_instr[11:7]),
        .i_wdata  (w_wd)
    );

    // One address adder serves both loads (I-immediate) and stores (S-immediate).
    assign w_is_store  = (w_op == OP_ST);
    assign o_dmem_addr = w_rs1 + (w_is_store ? w_imm_s : w_imm_i);
    assign w_off       = o_dmem_addr[1:0];
    assign w_ld_shift  = i_dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_ld_val = w_ld_shift;
        case (w_f3)
            3'b000:  w_ld_val = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_val = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_val = {16'd0, w_ld_shift[15:0]};
            default: w_ld_val = w_ld_shift;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = (w_rs1 == w_rs2);
            3'b001:  w_taken = (w_rs1 != w_rs2);
            3'b100:  w_taken = ($signed(w_rs1) < $signed(w_rs2));
            3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_taken = (w_rs1 < w_rs2);
            3'b111:  w_taken = (w_rs1 >= w_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_pc4;
        w_we      = 1'b0;
        w_wd      = 32'h0;
        w_be_raw  = 4'b0000;
        case (w_op)
            OP_LUI:   begin w_we = 1'b1; w_wd = w_imm_u; end
            OP_AUIPC: begin w_we = 1'b1; w_wd = r_pc + w_imm_u; end
            OP_JAL: begin
                w_we = 1'b1; w_wd = w_pc4; w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_we = 1'b1; w_wd = w_pc4; w_next_pc = (w_rs1 + w_imm_i) & ~32'd1;
            end
            OP_BR: if (w_taken) w_next_pc = r_pc + w_imm_b;
            OP_LD: begin
                w_we = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                       (w_f3 == 3'b100) || (w_f3 == 3'b101);
                w_wd = w_ld_val;
            end
            OP_ST: begin
                case (w_f3)
                    3'b000:  w_be_raw = 4'b0001;
                    3'b001:  w_be_raw = 4'b0011;
                    3'b010:  w_be_raw = 4'b1111;
                    default: w_be_raw = 4'b0000;
                endcase
            end
            OP_IMM: begin
                w_we = 1'b1;
                w_wd = alu(w_f3, w_rs1, w_imm_i, (w_f3 == 3'b101) && i_instr[30]);
            end
            OP_REG: begin
                w_we = 1'b1;
                w_wd = alu(w_f3, w_rs1, w_rs2, i_instr[30]);
            end
            default: ;
        endcase
    end

    // Lanes that shift past byte 3 are dropped, which clips misaligned stores to one word.
    assign o_dmem_be    = i_rst ? 4'b0000 : 4'(w_be_raw << w_off);
    assign o_dmem_wdata = w_rs2 << {w_off, 3'b000};
    assign o_pc         = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pc <= RESET_PC;
        else       r_pc <= w_next_pc;
    end
endmodule

module riscv_soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    logic [31:0] w_pc, w_instr, w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
    logic [3:0]  w_dmem_be;
    logic        w_unused;

    riscv_core #(.RESET_PC(RESET_PC)) riscv_inst (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr      (w_instr),
        .o_pc         (w_pc),
        .o_dmem_addr  (w_dmem_addr),
        .o_dmem_wdata (w_dmem_wdata),
        .o_dmem_be    (w_dmem_be),
        .i_dmem_rdata (w_dmem_rdata)
    );

    riscv_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
        .i_clk   (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata (32'h0),
        .i_addr  (w_pc[ROM_AW+1:2]),
        .o_data  (w_instr)
    );

`ifdef RISCV_SOC_DATA_RAM_EN
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [31:0]       ram_mem [0:RAM_DEPTH-1];
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_ram_idx = w_dmem_addr[RAM_AW+1:2];

    // RAM contents survive reset; only the core state is cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_dmem_be[b]) ram_mem[w_ram_idx][b*8 +: 8] <= w_dmem_wdata[b*8 +: 8];
        end
    end

    assign w_dmem_rdata = ram_mem[w_ram_idx];
    assign w_unused     = ^{w_pc, w_dmem_addr};
`else
    assign w_dmem_rdata = 32'h0;
    assign w_unused     = ^{w_pc, w_dmem_addr, w_dmem_wdata, w_dmem_be, (RAM_DEPTH == 0)};
`endif
endmodule

// File: tb/tb_riscv_soc.sv
// Directed-program bench for riscv_soc: loads small ROM images, steps the clock and checks
// pc and register contents against hand-computed values.

module tb_riscv_soc;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [31:0] prog[$];
    logic [31:0] pc_exp[$];

    riscv_soc dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_and_reset();
        rst = 1'b1;
        for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] <= 32'h0;
        @(negedge clk);
        for (int i = 0; i < prog.size(); i++) dut.rom_inst.rom_mem[i] <= prog[i];
        step(2);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rf(input int idx);
        return dut.riscv_inst.regs_inst.regs[idx];
    endfunction

    function automatic logic [31:0] regs_or();
        logic [31:0] acc;
        acc = 32'h0;
        for (int i = 0; i < 32; i++) acc = acc | dut.riscv_inst.regs_inst.regs[i];
        return acc;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;

        // Arithmetic / logic program
        prog = {
            enc_i(32'hFFF, 0, 0, 1, 32'h13),   // addi x1,x0,-1
            enc_i(3, 1, 0, 2, 32'h13),         // addi x2,x1,3
            enc_r(0, 2, 1, 3, 3),              // sltu x3,x1,x2
            enc_r(0, 2, 1, 2, 4),              // slt  x4,x1,x2
            enc_r(32'h20, 1, 2, 0, 5),         // sub  x5,x2,x1
            enc_u(32'h80000, 7, 32'h37),       // lui  x7,0x80000
            enc_i(32'h404, 7, 5, 6, 32'h13),   // srai x6,x7,4
            enc_i(4, 7, 5, 8, 32'h13),         // srli x8,x7,4
            enc_r(0, 5, 2, 1, 9),              // sll  x9,x2,x5
            enc_i(32'h0F0, 1, 4, 10, 32'h13),  // xori x10,x1,0xF0
            enc_u(1, 11, 32'h17),              // auipc x11,1
            enc_i(5, 1, 0, 0, 32'h13),         // addi x0,x1,5
            enc_r(32'h20, 1, 7, 5, 12),        // sra  x12,x7,x1
            enc_i(32'h7FF, 10, 7, 13, 32'h13)  // andi x13,x10,0x7FF
        };
        load_and_reset();
        check("reset_pc", dut.riscv_inst.r_pc, 32'h0);
        check("reset_regs", regs_or(), 32'h0);
        step(14);
        check("alu_pc", dut.riscv_inst.r_pc, 32'h38);
        check("addi_neg", rf(1), 32'hFFFF_FFFF);
        check("addi_wrap", rf(2), 32'h2);
        check("sltu", rf(3), 32'h0);
        check("slt", rf(4), 32'h1);
        check("sub", rf(5), 32'h3);
        check("lui", rf(7), 32'h8000_0000);
        check("srai", rf(6), 32'hF800_0000);
        check("srli", rf(8), 32'h0800_0000);
        check("sll", rf(9), 32'h10);
        check("xori", rf(10), 32'hFFFF_FF0F);
        check("auipc", rf(11), 32'h1028);
        check("x0_write", rf(0), 32'h0);
        check("sra_shamt", rf(12), 32'hFFFF_FFFF);
        check("andi", rf(13), 32'h70F);

        // Reset mid-program
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_pc", dut.riscv_inst.r_pc, 32'h0);
        check("midrst_regs", regs_or(), 32'h0);

        // Jumps and unknown opcode
        prog = {
            enc_i(32'h10, 0, 0, 5, 32'h13),    // 0x00 addi x5,x0,0x10
            32'h0000_0F8B,                     // 0x04 custom opcode, rd=x31
            enc_i(0, 5, 0, 5, 32'h67),         // 0x08 jalr x5,x5,0
            enc_i(1, 0, 0, 20, 32'h13),        // 0x0c addi x20,x0,1 (skipped)
            enc_i(7, 0, 0, 6, 32'h13),         // 0x10 addi x6,x0,7
            enc_j(32'hFFFF_FFFC, 0)            // 0x14 jal x0,-4
        };
        load_and_reset();
        step(2);
        check("nop_pc", dut.riscv_inst.r_pc, 32'h8);
        check("nop_x31", rf(31), 32'h0);
        step(1);
        check("jalr_pc", dut.riscv_inst.r_pc, 32'h10);
        check("jalr_link", rf(5), 32'hC);
        step(2);
        check("jal_back_pc", dut.riscv_inst.r_pc, 32'h10);
        check("jal_x0", rf(0), 32'h0);
        check("loop_x6", rf(6), 32'h7);
        step(2);
        check("loop_pc", dut.riscv_inst.r_pc, 32'h10);
        check("skip_x20", rf(20), 32'h0);

        // Branches
        prog = {
            enc_i(32'hFFF, 0, 0, 1, 32'h13),   // 0x00 addi x1,x0,-1
            enc_i(1, 0, 0, 2, 32'h13),         // 0x04 addi x2,x0,1
            enc_b(8, 1, 1, 0),                 // 0x08 beq  x1,x1,+8  taken
            enc_i(1, 0, 0, 20, 32'h13),        // 0x0c skipped
            enc_b(8, 2, 1, 0),                 // 0x10 beq  x1,x2     not taken
            enc_b(8, 2, 1, 6),                 // 0x14 bltu x1,x2     not taken
            enc_b(8, 2, 1, 5),                 // 0x18 bge  x1,x2     not taken
            enc_b(8, 2, 1, 4),                 // 0x1c blt  x1,x2,+8  taken
            enc_i(1, 0, 0, 21, 32'h13),        // 0x20 skipped
            enc_b(8, 2, 1, 7),                 // 0x24 bgeu x1,x2,+8  taken
            enc_i(1, 0, 0, 21, 32'h13),        // 0x28 skipped
            enc_j(8, 22),                      // 0x2c jal  x22,+8
            enc_i(1, 0, 0, 21, 32'h13),        // 0x30 skipped
            enc_i(5, 22, 0, 23, 32'h67)        // 0x34 jalr x23,x22,5 -> 0x34
        };
        pc_exp = {32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h24, 32'h2c, 32'h34, 32'h34};
        load_and_reset();
        for (int i = 0; i < pc_exp.size(); i++) begin
            step(1);
            check($sformatf("br_pc%0d", i), dut.riscv_inst.r_pc, pc_exp[i]);
        end
        check("br_skip20", rf(20), 32'h0);
        check("br_skip21", rf(21), 32'h0);
        check("jal_link", rf(22), 32'h30);
        check("jalr_odd_link", rf(23), 32'h38);

        // Loads and stores
        prog = {
            enc_u(32'h80FF8, 1, 32'h37),       // lui  x1,0x80FF8
            enc_i(32'hF01, 1, 0, 1, 32'h13),   // addi x1,x1,-255 -> 80FF7F01
            enc_i(32'h100, 0, 0, 2, 32'h13),   // addi x2,x0,0x100
            enc_s(0, 1, 2, 2),                 // sw   x1,0(x2)
            enc_i(3, 2, 0, 3, 32'h03),         // lb   x3,3(x2)
            enc_i(0, 2, 5, 4, 32'h03),         // lhu  x4,0(x2)
            enc_i(32'h55, 0, 0, 5, 32'h13),    // addi x5,x0,0x55
            enc_s(1, 5, 2, 0),                 // sb   x5,1(x2)
            enc_i(0, 2, 2, 6, 32'h03),         // lw   x6,0(x2)
            enc_i(2, 2, 1, 7, 32'h03),         // lh   x7,2(x2)
            enc_i(3, 2, 4, 8, 32'h03),         // lbu  x8,3(x2)
            enc_s(2, 5, 2, 1),                 // sh   x5,2(x2)
            enc_i(0, 2, 2, 9, 32'h03)          // lw   x9,0(x2)
        };
        load_and_reset();
        step(13);
        check("mem_pc", dut.riscv_inst.r_pc, 32'h34);
        check("mem_x1", rf(1), 32'h80FF_7F01);
`ifdef RISCV_SOC_DATA_RAM_EN
        check("lb", rf(3), 32'hFFFF_FF80);
        check("lhu", rf(4), 32'h0000_7F01);
        check("sb_lw", rf(6), 32'h80FF_5501);
        check("lh", rf(7), 32'hFFFF_80FF);
        check("lbu", rf(8), 32'h0000_0080);
        check("sh_lw", rf(9), 32'h0055_5501);
`else
        check("lb_noram", rf(3), 32'h0);
        check("lhu_noram", rf(4), 32'h0);
        check("lw_noram", rf(6), 32'h0);
        check("lh_noram", rf(7), 32'h0);
        check("lbu_noram", rf(8), 32'h0);
        check("lw2_noram", rf(9), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
